// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: opcodes, functs, ALU ops, control word.
// The optional jal/jr support is selected by MIPS_JAL_JR_EN in mips_single_cycle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef struct packed {
        logic RegDst;
        logic ALUSrc;
        logic MemtoReg;
        logic RegWrite;
        logic MemRead;
        logic MemWrite;
        logic Branch;
        logic Jump;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_alu.sv
// 32-bit integer ALU for the single-cycle MIPS core; results wrap, no overflow trap.
module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_e     op_i,
    output logic [31:0] result_o,
    output logic        zero_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SLT: result_o = {31'b0, $signed(a_i) < $signed(b_i)};
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/mips_single_cycle.sv
// Single-cycle MIPS core: PC, register file, decoder and next-PC logic around mips_alu.
// Define MIPS_JAL_JR_EN to add jal/jr; without it both decode as NOP.
module mips_single_cycle
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] InstAddr,
    output logic [31:0] DataAddr,
    output logic [31:0] WriteMem,
    input  logic [31:0] Inst,
    input  logic [31:0] MemOut,
    output logic [31:0] inn,
    output logic [5:0]  oppc,
    output logic        rgw
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [NUM_REGS];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs_idx, rt_idx, rd_idx, wr_idx;
    logic [31:0] imm_sext, rs_val, rt_val, alu_b, alu_y, wr_data;
    logic [31:0] pc_plus4, br_target, jmp_target;
    logic        alu_zero, link, jump_reg, reg_we;
    ctrl_t       ctrl;
    alu_op_e     alu_op;

    assign opcode   = Inst[31:26];
    assign rs_idx   = Inst[25:21];
    assign rt_idx   = Inst[20:16];
    assign rd_idx   = Inst[15:11];
    assign funct    = Inst[5:0];
    assign imm_sext = sext16(Inst[15:0]);

    // Index 0 and any index beyond the implemented file read as zero.
    assign rs_val = (rs_idx == '0 || 32'(rs_idx) >= NUM_REGS) ? '0 : regs_q[rs_idx];
    assign rt_val = (rt_idx == '0 || 32'(rt_idx) >= NUM_REGS) ? '0 : regs_q[rt_idx];

    always_comb begin
        ctrl     = CTRL_NOP;
        alu_op   = ALU_ADD;
        link     = 1'b0;
        jump_reg = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.RegDst   = 1'b1;
                ctrl.RegWrite = 1'b1;
                case (funct)
                    FN_ADD: alu_op = ALU_ADD;
                    FN_SUB: alu_op = ALU_SUB;
                    FN_AND: alu_op = ALU_AND;
                    FN_OR:  alu_op = ALU_OR;
                    FN_SLT: alu_op = ALU_SLT;
`ifdef MIPS_JAL_JR_EN
                    FN_JR: begin
                        ctrl     = CTRL_NOP;
                        jump_reg = 1'b1;
                    end
`endif
                    default: ctrl = CTRL_NOP;
                endcase
            end
            OP_ADDI: begin
                ctrl.ALUSrc   = 1'b1;
                ctrl.RegWrite = 1'b1;
            end
            OP_SLTI: begin
                ctrl.ALUSrc   = 1'b1;
                ctrl.RegWrite = 1'b1;
                alu_op        = ALU_SLT;
            end
            OP_LW: begin
                ctrl.ALUSrc   = 1'b1;
                ctrl.MemtoReg = 1'b1;
                ctrl.RegWrite = 1'b1;
                ctrl.MemRead  = 1'b1;
            end
            OP_SW: begin
                ctrl.ALUSrc   = 1'b1;
                ctrl.MemWrite = 1'b1;
            end
            OP_BEQ: begin
                ctrl.Branch = 1'b1;
                alu_op      = ALU_SUB;
            end
            OP_J: ctrl.Jump = 1'b1;
`ifdef MIPS_JAL_JR_EN
            OP_JAL: begin
                ctrl.Jump     = 1'b1;
                ctrl.RegWrite = 1'b1;
                link          = 1'b1;
            end
`endif
            default: ctrl = CTRL_NOP;
        endcase
    end

    assign alu_b = ctrl.ALUSrc ? imm_sext : rt_val;

    mips_alu u_alu (
        .a_i      (rs_val),
        .b_i      (alu_b),
        .op_i     (alu_op),
        .result_o (alu_y),
        .zero_o   (alu_zero)
    );

    assign pc_plus4   = pc_q + 32'd4;
    assign br_target  = pc_plus4 + (imm_sext << 2);
    assign jmp_target = {pc_plus4[31:28], Inst[25:0], 2'b00};

    always_comb begin
        pc_d = pc_plus4;
        if (jump_reg)
            pc_d = rs_val;
        else if (ctrl.Jump)
            pc_d = jmp_target;
        else if (ctrl.Branch && alu_zero)
            pc_d = br_target;
    end

    assign wr_idx  = link ? 5'd31 : (ctrl.RegDst ? rd_idx : rt_idx);
    assign wr_data = link ? pc_plus4 : (ctrl.MemtoReg ? MemOut : alu_y);
    assign reg_we  = ctrl.RegWrite && (wr_idx != '0) && (32'(wr_idx) < NUM_REGS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pc_q <= PC_RESET;
        else
            pc_q <= pc_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            regs_q <= '{default: '0};
        else if (reg_we)
            regs_q[wr_idx] <= wr_data;
    end

    assign InstAddr = pc_q;
    assign DataAddr = rs_val + imm_sext;
    assign WriteMem = rt_val;
    assign MemRead  = ctrl.MemRead;
    assign MemWrite = ctrl.MemWrite & rst;
    assign inn      = Inst;
    assign oppc     = opcode;
    assign rgw      = ctrl.RegWrite;

endmodule

// File: tb/tb_mips_single_cycle.sv
// Scoreboard bench for mips_single_cycle: per-cycle expectations queued by stimulus, checked at negedge.
module tb_mips_single_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, rgw;
    logic [31:0] InstAddr, DataAddr, WriteMem, Inst, MemOut, inn;
    logic [5:0]  oppc;

    logic [31:0] imem [16];
    logic [31:0] dmem [512];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic        full;
        logic        mem;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [5:0]  op;
        logic        mr;
        logic        mw;
        logic        rgw;
        logic [31:0] da;
        logic [31:0] wm;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    mips_single_cycle #(
        .PC_RESET (32'h0000_0000),
        .NUM_REGS (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .InstAddr (InstAddr),
        .DataAddr (DataAddr),
        .WriteMem (WriteMem),
        .Inst     (Inst),
        .MemOut   (MemOut),
        .inn      (inn),
        .oppc     (oppc),
        .rgw      (rgw)
    );

    assign Inst   = imem[InstAddr[5:2]];
    assign MemOut = dmem[DataAddr[10:2]];

    always @(posedge clk) begin
        if (!rst)
            dmem[250] <= 32'h0000_00AA;
        else if (MemWrite)
            dmem[DataAddr[10:2]] <= WriteMem;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                                input logic mr, input logic mw, input logic rg,
                                input logic [31:0] da, input logic [31:0] wm);
        exp_t e;
        e.tag  = tag;
        e.full = 1'b1;
        e.mem  = mr | mw;
        e.pc   = pc;
        e.inst = inst;
        e.op   = inst[31:26];
        e.mr   = mr;
        e.mw   = mw;
        e.rgw  = rg;
        e.da   = da;
        e.wm   = wm;
        return e;
    endfunction

    function automatic exp_t mk_rst(input string tag);
        exp_t e;
        e      = mk(tag, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        e.full = 1'b0;
        e.mem  = 1'b0;
        return e;
    endfunction

    task automatic step(input exp_t e, input logic r);
        @(posedge clk);
        #1;
        rst = r;
        q.push_back(e);
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, ".InstAddr"}, InstAddr, e.pc);
                chk({e.tag, ".MemWrite"}, {31'b0, MemWrite}, {31'b0, e.mw});
                if (e.full) begin
                    chk({e.tag, ".inn"}, inn, e.inst);
                    chk({e.tag, ".oppc"}, {26'b0, oppc}, {26'b0, e.op});
                    chk({e.tag, ".MemRead"}, {31'b0, MemRead}, {31'b0, e.mr});
                    chk({e.tag, ".rgw"}, {31'b0, rgw}, {31'b0, e.rgw});
                end
                if (e.mem) begin
                    chk({e.tag, ".DataAddr"}, DataAddr, e.da);
                    chk({e.tag, ".WriteMem"}, WriteMem, e.wm);
                end
            end
        end
    end

    initial begin
        rst  = 1'b0;
        imem = '{default: 32'h0};
        imem[0] = 32'hACE1_0020;  // sw  $1,0x20($7)
        imem[1] = 32'h2005_FFFF;  // addi $5,$0,-1
        imem[2] = 32'h0005_3022;  // sub $6,$0,$5
        imem[3] = 32'h00A6_382A;  // slt $7,$5,$6
        imem[4] = 32'h28A8_0000;  // slti $8,$5,0
        imem[5] = 32'h00A6_4824;  // and $9,$5,$6
        imem[6] = 32'h00C5_5025;  // or  $10,$6,$5
        imem[7] = 32'hACC7_0000;  // sw  $7,0($6)
        imem[8] = 32'hAD28_0000;  // sw  $8,0($9)
        imem[9] = 32'hAD4A_0010;  // sw  $10,0x10($10)

        step(mk_rst("rstA0"), 1'b0);
        step(mk_rst("rstA1"), 1'b0);
        step(mk("A0", 32'h00, imem[0], 0, 1, 0, 32'h20, 32'h0), 1'b1);
        step(mk("A1", 32'h04, imem[1], 0, 0, 1, 32'h0, 32'h0), 1'b1);
        step(mk("A2", 32'h08, imem[2], 0, 0, 1, 32'h0, 32'h0), 1'b1);
        step(mk("A3", 32'h0C, imem[3], 0, 0, 1, 32'h0, 32'h0), 1'b1);
        step(mk("A4", 32'h10, imem[4], 0, 0, 1, 32'h0, 32'h0), 1'b1);
        step(mk("A5", 32'h14, imem[5], 0, 0, 1, 32'h0, 32'h0), 1'b1);
        step(mk("A6", 32'h18, imem[6], 0, 0, 1, 32'h0, 32'h0), 1'b1);
        step(mk("A7", 32'h1C, imem[7], 0, 1, 0, 32'h1, 32'h1), 1'b1);
        step(mk("A8", 32'h20, imem[8], 0, 1, 0, 32'h1, 32'h1), 1'b1);
        step(mk("A9", 32'h24, imem[9], 0, 1, 0, 32'hF, 32'hFFFF_FFFF), 1'b1);

        // Reset asserted while PC=0x28: PC must clear at once.
        step(mk_rst("rstB0"), 1'b0);
        imem = '{default: 32'h0};
        imem[0] = 32'h2001_0005;  // addi $1,$0,5
        imem[1] = 32'h2002_0007;  // addi $2,$0,7
        imem[2] = 32'h0022_1820;  // add $3,$1,$2
        imem[3] = 32'h8C04_03E8;  // lw  $4,1000($0)
        imem[4] = 32'h1021_0002;  // beq $1,$1,+2
        imem[5] = 32'hACA3_03F0;  // sw  $3,1008($5)
        imem[6] = 32'hFC00_0000;  // unknown opcode
        imem[7] = 32'hAC04_03EC;  // sw  $4,1004($0)
        imem[8] = 32'h0800_0004;  // j 4
        step(mk_rst("rstB1"), 1'b0);
        step(mk("B0", 32'h00, 32'h2001_0005, 0, 0, 1, 32'h0, 32'h0), 1'b1);
        step(mk("B1", 32'h04, 32'h2002_0007, 0, 0, 1, 32'h0, 32'h0), 1'b1);
        step(mk("B2", 32'h08, 32'h0022_1820, 0, 0, 1, 32'h0, 32'h0), 1'b1);
        step(mk("B3", 32'h0C, 32'h8C04_03E8, 1, 0, 1, 32'h3E8, 32'h0), 1'b1);
        step(mk("B4", 32'h10, 32'h1021_0002, 0, 0, 0, 32'h0, 32'h0), 1'b1);
        step(mk("B5", 32'h1C, 32'hAC04_03EC, 0, 1, 0, 32'h3EC, 32'hAA), 1'b1);
        imem[4] = 32'h1022_0002;  // beq $1,$2,+2 (not taken)
        step(mk("B6", 32'h20, 32'h0800_0004, 0, 0, 0, 32'h0, 32'h0), 1'b1);
        step(mk("B7", 32'h10, 32'h1022_0002, 0, 0, 0, 32'h0, 32'h0), 1'b1);
        step(mk("B8", 32'h14, 32'hACA3_03F0, 0, 1, 0, 32'h3F0, 32'hC), 1'b1);
        step(mk("B9", 32'h18, 32'hFC00_0000, 0, 0, 0, 32'h0, 32'h0), 1'b1);
        step(mk("B10", 32'h1C, 32'hAC04_03EC, 0, 1, 0, 32'h3EC, 32'hAA), 1'b1);
        step(mk("B11", 32'h20, 32'h0800_0004, 0, 0, 0, 32'h0, 32'h0), 1'b1);

        step(mk_rst("rstC0"), 1'b0);
        imem = '{default: 32'h0};
        imem[0] = 32'h2000_0001;  // addi $0,$0,1 (write discarded)
        imem[1] = 32'h0C00_0008;  // jal 8
        imem[2] = 32'hAC1F_0000;  // sw  $31,0($0)
        imem[3] = 32'h0800_0008;  // j 8
        imem[8] = 32'h03E0_0008;  // jr $31
        imem[9] = 32'h0800_0000;  // j 0
        step(mk_rst("rstC1"), 1'b0);
        step(mk("C0", 32'h00, 32'h2000_0001, 0, 0, 1, 32'h0, 32'h0), 1'b1);
`ifdef MIPS_JAL_JR_EN
        step(mk("C1", 32'h04, 32'h0C00_0008, 0, 0, 1, 32'h0, 32'h0), 1'b1);
        step(mk("C2", 32'h20, 32'h03E0_0008, 0, 0, 0, 32'h0, 32'h0), 1'b1);
        step(mk("C3", 32'h08, 32'hAC1F_0000, 0, 1, 0, 32'h0, 32'h8), 1'b1);
        step(mk("C4", 32'h0C, 32'h0800_0008, 0, 0, 0, 32'h0, 32'h0), 1'b1);
        step(mk("C5", 32'h20, 32'h03E0_0008, 0, 0, 0, 32'h0, 32'h0), 1'b1);
`else
        step(mk("C1", 32'h04, 32'h0C00_0008, 0, 0, 0, 32'h0, 32'h0), 1'b1);
        step(mk("C2", 32'h08, 32'hAC1F_0000, 0, 1, 0, 32'h0, 32'h0), 1'b1);
        step(mk("C3", 32'h0C, 32'h0800_0008, 0, 0, 0, 32'h0, 32'h0), 1'b1);
        step(mk("C4", 32'h20, 32'h03E0_0008, 0, 0, 0, 32'h0, 32'h0), 1'b1);
        step(mk("C5", 32'h24, 32'h0800_0000, 0, 0, 0, 32'h0, 32'h0), 1'b1);
        step(mk("C6", 32'h00, 32'h2000_0001, 0, 0, 1, 32'h0, 32'h0), 1'b1);
`endif

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        chk("dmem[251]", dmem[251], 32'h0000_00AA);
        chk("dmem[252]", dmem[252], 32'h0000_000C);
        chk("dmem[3]", dmem[3], 32'hFFFF_FFFF);
        chk("dmem[8]", dmem[8], 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
